// File: rtl/rf_sequencer.sv
// Command sequencer for the 8-register file: expands one accepted command into strobe cycles.
// Define RF_SEQ_READBACK_EN to implement the READ op (dual readback through O1/O2).
module rf_sequencer (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [2:0] cmd_op,
    input  logic [7:0] cmd_dst,
    input  logic [2:0] cmd_src,
    input  logic [7:0] cmd_data,
    input  logic [3:0] cmd_count,
    output logic [7:0] rf_I,
    output logic [1:0] rf_FunSel,
    output logic [3:0] rf_RSel,
    output logic [3:0] rf_TSel,
    output logic [2:0] rf_O1Sel,
    output logic [2:0] rf_O2Sel,
    input  logic [7:0] rf_O1,
    input  logic [7:0] rf_O2,
    output logic       busy,
    output logic       done,
    output logic [7:0] rd_data1,
    output logic [7:0] rd_data2,
    output logic       rd_valid
);
    localparam logic [2:0] OP_CLR  = 3'b001;
    localparam logic [2:0] OP_LOAD = 3'b010;
    localparam logic [2:0] OP_INC  = 3'b011;
    localparam logic [2:0] OP_DEC  = 3'b100;
    localparam logic [2:0] OP_MOVE = 3'b101;
`ifdef RF_SEQ_READBACK_EN
    localparam logic [2:0] OP_READ = 3'b110;
`endif

    typedef enum logic [2:0] {S_IDLE, S_EXEC, S_ISSUE, S_CAPTURE, S_WRITE} state_t;

    state_t     r_state, w_state;
    logic [7:0] r_I, w_I;
    logic [1:0] r_fun, w_fun;
    logic [3:0] r_rsel, w_rsel;
    logic [3:0] r_tsel, w_tsel;
    logic [2:0] r_o1sel, w_o1sel;
    logic [7:0] r_dst, w_dst;
    logic [3:0] r_cnt, w_cnt;
    logic       r_done, w_done;
    logic       w_accept;
`ifdef RF_SEQ_READBACK_EN
    logic [2:0] r_o2sel, w_o2sel;
    logic       r_is_read, w_is_read;
    logic [7:0] r_rd1, w_rd1;
    logic [7:0] r_rd2, w_rd2;
    logic       r_rdv, w_rdv;
`else
    logic       w_unused_o2;
    assign w_unused_o2 = ^rf_O2;
`endif

    assign cmd_ready = (r_state == S_IDLE) && !rst;
    assign w_accept  = cmd_valid && cmd_ready;

    // Outputs are registered: the strobe for a state is computed on the edge that enters it.
    always_comb begin
        w_state = r_state;
        w_I     = r_I;
        w_fun   = r_fun;
        w_rsel  = '0;
        w_tsel  = '0;
        w_o1sel = r_o1sel;
        w_dst   = r_dst;
        w_cnt   = r_cnt;
        w_done  = 1'b0;
`ifdef RF_SEQ_READBACK_EN
        w_o2sel   = r_o2sel;
        w_is_read = r_is_read;
        w_rd1     = r_rd1;
        w_rd2     = r_rd2;
        w_rdv     = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_dst = cmd_dst;
                    w_cnt = '0;
                    case (cmd_op)
                        OP_CLR, OP_LOAD: begin
                            w_fun   = (cmd_op == OP_CLR) ? 2'b00 : 2'b01;
                            w_I     = (cmd_op == OP_LOAD) ? cmd_data : r_I;
                            w_rsel  = cmd_dst[7:4];
                            w_tsel  = cmd_dst[3:0];
                            w_state = S_EXEC;
                        end
                        OP_INC, OP_DEC: begin
                            if (cmd_count == 4'd0) begin
                                w_done = 1'b1;
                            end else begin
                                w_fun   = (cmd_op == OP_INC) ? 2'b11 : 2'b10;
                                w_rsel  = cmd_dst[7:4];
                                w_tsel  = cmd_dst[3:0];
                                w_cnt   = cmd_count - 4'd1;
                                w_state = S_EXEC;
                            end
                        end
                        OP_MOVE: begin
                            w_o1sel = cmd_src;
`ifdef RF_SEQ_READBACK_EN
                            w_is_read = 1'b0;
`endif
                            w_state = S_ISSUE;
                        end
`ifdef RF_SEQ_READBACK_EN
                        OP_READ: begin
                            w_o1sel   = cmd_src;
                            w_o2sel   = cmd_data[2:0];
                            w_is_read = 1'b1;
                            w_state   = S_ISSUE;
                        end
`endif
                        default: w_done = 1'b1;
                    endcase
                end
            end
            S_EXEC: begin
                if (r_cnt != 4'd0) begin
                    w_rsel = r_dst[7:4];
                    w_tsel = r_dst[3:0];
                    w_cnt  = r_cnt - 4'd1;
                end else begin
                    w_done  = 1'b1;
                    w_state = S_IDLE;
                end
            end
            S_ISSUE: w_state = S_CAPTURE;
            S_CAPTURE: begin
`ifdef RF_SEQ_READBACK_EN
                if (r_is_read) begin
                    w_rd1   = rf_O1;
                    w_rd2   = rf_O2;
                    w_rdv   = 1'b1;
                    w_done  = 1'b1;
                    w_state = S_IDLE;
                end else
`endif
                begin
                    // rf_I doubles as the MOVE holding register.
                    w_I     = rf_O1;
                    w_fun   = 2'b01;
                    w_rsel  = r_dst[7:4];
                    w_tsel  = r_dst[3:0];
                    w_state = S_WRITE;
                end
            end
            S_WRITE: begin
                w_done  = 1'b1;
                w_state = S_IDLE;
            end
            default: w_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_I     <= '0;
            r_fun   <= '0;
            r_rsel  <= '0;
            r_tsel  <= '0;
            r_o1sel <= '0;
            r_dst   <= '0;
            r_cnt   <= '0;
            r_done  <= 1'b0;
`ifdef RF_SEQ_READBACK_EN
            r_o2sel   <= '0;
            r_is_read <= 1'b0;
            r_rd1     <= '0;
            r_rd2     <= '0;
            r_rdv     <= 1'b0;
`endif
        end else begin
            r_state <= w_state;
            r_I     <= w_I;
            r_fun   <= w_fun;
            r_rsel  <= w_rsel;
            r_tsel  <= w_tsel;
            r_o1sel <= w_o1sel;
            r_dst   <= w_dst;
            r_cnt   <= w_cnt;
            r_done  <= w_done;
`ifdef RF_SEQ_READBACK_EN
            r_o2sel   <= w_o2sel;
            r_is_read <= w_is_read;
            r_rd1     <= w_rd1;
            r_rd2     <= w_rd2;
            r_rdv     <= w_rdv;
`endif
        end
    end

    assign rf_I      = r_I;
    assign rf_FunSel = r_fun;
    assign rf_RSel   = r_rsel;
    assign rf_TSel   = r_tsel;
    assign rf_O1Sel  = r_o1sel;
    assign busy      = (r_state != S_IDLE);
    assign done      = r_done;
`ifdef RF_SEQ_READBACK_EN
    assign rf_O2Sel  = r_o2sel;
    assign rd_data1  = r_rd1;
    assign rd_data2  = r_rd2;
    assign rd_valid  = r_rdv;
`else
    assign rf_O2Sel  = '0;
    assign rd_data1  = '0;
    assign rd_data2  = '0;
    assign rd_valid  = 1'b0;
`endif
endmodule

// File: tb/tb_rf_sequencer.sv
// Scoreboard bench for rf_sequencer with a behavioural 8-register file model.
module tb_rf_sequencer;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [2:0] cmd_op = '0;
    logic [7:0] cmd_dst = '0;
    logic [2:0] cmd_src = '0;
    logic [7:0] cmd_data = '0;
    logic [3:0] cmd_count = '0;
    logic [7:0] rf_I;
    logic [1:0] rf_FunSel;
    logic [3:0] rf_RSel, rf_TSel;
    logic [2:0] rf_O1Sel, rf_O2Sel;
    logic [7:0] rf_O1 = '0;
    logic [7:0] rf_O2 = '0;
    logic       busy, done, rd_valid;
    logic [7:0] rd_data1, rd_data2;

    always #5 clk = ~clk;

    rf_sequencer dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_dst(cmd_dst), .cmd_src(cmd_src), .cmd_data(cmd_data),
        .cmd_count(cmd_count), .rf_I(rf_I), .rf_FunSel(rf_FunSel), .rf_RSel(rf_RSel),
        .rf_TSel(rf_TSel), .rf_O1Sel(rf_O1Sel), .rf_O2Sel(rf_O2Sel), .rf_O1(rf_O1),
        .rf_O2(rf_O2), .busy(busy), .done(done), .rd_data1(rd_data1),
        .rd_data2(rd_data2), .rd_valid(rd_valid)
    );

    // Register file: index 0..3 = T1..T4, 4..7 = R1..R4 (same as the O1Sel/O2Sel codes).
    logic [7:0] rf [0:7] = '{default: 8'h00};

    function automatic logic [7:0] rf_apply(input logic [7:0] v);
        case (rf_FunSel)
            2'b00:   return 8'h00;
            2'b01:   return rf_I;
            2'b10:   return v - 8'd1;
            default: return v + 8'd1;
        endcase
    endfunction

    always @(posedge clk) begin
        rf_O1 <= rf[rf_O1Sel];
        rf_O2 <= rf[rf_O2Sel];
        for (int b = 0; b < 4; b++) begin
            if (rf_RSel[b]) rf[7-b] <= rf_apply(rf[7-b]);
            if (rf_TSel[b]) rf[3-b] <= rf_apply(rf[3-b]);
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    typedef struct {
        string      nm;
        int         cyc;
        int         ns;
        logic [3:0] rs;
        logic [3:0] ts;
        logic [1:0] fn;
        logic [7:0] iv;
        logic       rdv;
        logic [7:0] d1;
        logic [7:0] d2;
        logic [63:0] regs;
    } exp_t;

    exp_t q[$];
    logic [7:0] exp_rf [0:7] = '{default: 8'h00};
    int acc_cyc = 0;

    function automatic logic [63:0] pack_exp();
        logic [63:0] s;
        for (int i = 0; i < 8; i++) s[i*8 +: 8] = exp_rf[i];
        return s;
    endfunction

    function automatic logic [63:0] pack_rf();
        logic [63:0] s;
        for (int i = 0; i < 8; i++) s[i*8 +: 8] = rf[i];
        return s;
    endfunction

    task automatic expect_done(input string nm, input int lat, input int ns,
                               input logic [3:0] rs, input logic [3:0] ts,
                               input logic [1:0] fn, input logic [7:0] iv,
                               input logic rdv, input logic [7:0] d1, input logic [7:0] d2);
        exp_t e;
        e.nm = nm; e.cyc = acc_cyc + lat; e.ns = ns; e.rs = rs; e.ts = ts;
        e.fn = fn; e.iv = iv; e.rdv = rdv; e.d1 = d1; e.d2 = d2; e.regs = pack_exp();
        q.push_back(e);
    endtask

    // Monitor: tracks strobe cycles and checks each done pulse against the queue head.
    int         m_ns = 0;
    logic [3:0] m_rs, m_ts;
    logic [1:0] m_fn;
    logic [7:0] m_iv;
    exp_t       m_e;
    always @(negedge clk) begin
        if (rf_RSel != 4'd0 || rf_TSel != 4'd0) begin
            m_ns++;
            m_rs = rf_RSel; m_ts = rf_TSel; m_fn = rf_FunSel; m_iv = rf_I;
        end
        if (rd_valid && !done) begin
            checks++; errors++;
            $display("FAIL rd_valid_alone: got rd_valid=1 with done=0, expected 0");
        end
        if (done) begin
            if (q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_done: got done=1 at cycle %0d, expected no done", cyc);
            end else begin
                m_e = q.pop_front();
                chk({m_e.nm, "_done_cycle"}, cyc, m_e.cyc);
                chk({m_e.nm, "_strobes"}, m_ns, m_e.ns);
                if (m_e.ns > 0) begin
                    chk({m_e.nm, "_rsel"}, m_rs, m_e.rs);
                    chk({m_e.nm, "_tsel"}, m_ts, m_e.ts);
                    chk({m_e.nm, "_funsel"}, m_fn, m_e.fn);
                    chk({m_e.nm, "_I"}, m_iv, m_e.iv);
                end
                chk({m_e.nm, "_rd_valid"}, rd_valid, m_e.rdv);
                chk({m_e.nm, "_rd_data1"}, rd_data1, m_e.d1);
                chk({m_e.nm, "_rd_data2"}, rd_data2, m_e.d2);
                chk({m_e.nm, "_regs"}, pack_rf(), m_e.regs);
            end
            m_ns = 0;
        end else if (!busy) begin
            m_ns = 0;
        end
    end

    task automatic send(input logic [2:0] op, input logic [7:0] dst, input logic [2:0] src,
                        input logic [7:0] data, input logic [3:0] cnt);
        int w = 0;
        @(negedge clk);
        cmd_op = op; cmd_dst = dst; cmd_src = src; cmd_data = data; cmd_count = cnt;
        cmd_valid = 1'b1;
        while (!cmd_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        chk("accept_ready", cmd_ready, 1'b1);
        acc_cyc = cyc;
        @(posedge clk);
        #1;
        // Fields are scrambled after acceptance; the DUT must have latched them.
        cmd_valid = 1'b0;
        cmd_op = 3'b000; cmd_dst = ~dst; cmd_src = ~src; cmd_data = ~data; cmd_count = ~cnt;
    endtask

    task automatic drain();
        int w = 0;
        while (q.size() != 0 && w < 100) begin
            @(negedge clk);
            w++;
        end
        chk("drain_queue", q.size(), 0);
    endtask

    initial begin
        int a_inc;
        int n;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("ready_in_reset", cmd_ready, 1'b0);
        rst = 1'b0;
        #1;
        chk("reset_ready", cmd_ready, 1'b1);
        chk("reset_rf_outputs", {rf_I, rf_FunSel, rf_RSel, rf_TSel, rf_O1Sel, rf_O2Sel}, 0);
        chk("reset_flags", {busy, done, rd_valid}, 0);
        chk("reset_rd_data", {rd_data1, rd_data2}, 0);

        send(3'b010, 8'h80, 3'b000, 8'h5A, 4'd0);
        exp_rf[4] = 8'h5A;
        expect_done("load_r1", 2, 1, 4'h8, 4'h0, 2'b01, 8'h5A, 1'b0, 8'h00, 8'h00);

        send(3'b010, 8'h01, 3'b000, 8'hFE, 4'd0);
        exp_rf[3] = 8'hFE;
        expect_done("load_t4", 2, 1, 4'h0, 4'h1, 2'b01, 8'hFE, 1'b0, 8'h00, 8'h00);

        send(3'b011, 8'h01, 3'b000, 8'h00, 4'd3);
        exp_rf[3] = 8'h01;
        expect_done("inc3_wrap", 4, 3, 4'h0, 4'h1, 2'b11, 8'hFE, 1'b0, 8'h00, 8'h00);

        send(3'b101, 8'h10, 3'b100, 8'h00, 4'd0);
        exp_rf[7] = 8'h5A;
        expect_done("move_r1_r4", 4, 1, 4'h1, 4'h0, 2'b01, 8'h5A, 1'b0, 8'h00, 8'h00);

        send(3'b010, 8'h10, 3'b000, 8'h33, 4'd0);
        exp_rf[7] = 8'h33;
        expect_done("load_r4", 2, 1, 4'h1, 4'h0, 2'b01, 8'h33, 1'b0, 8'h00, 8'h00);

        send(3'b010, 8'h08, 3'b000, 8'hC7, 4'd0);
        exp_rf[0] = 8'hC7;
        expect_done("load_t1", 2, 1, 4'h0, 4'h8, 2'b01, 8'hC7, 1'b0, 8'h00, 8'h00);

        send(3'b110, 8'h00, 3'b111, 8'h00, 4'd0);
`ifdef RF_SEQ_READBACK_EN
        expect_done("read", 3, 0, 4'h0, 4'h0, 2'b00, 8'h00, 1'b1, 8'h33, 8'hC7);
`else
        expect_done("read_as_nop", 1, 0, 4'h0, 4'h0, 2'b00, 8'h00, 1'b0, 8'h00, 8'h00);
`endif

        send(3'b001, 8'h00, 3'b000, 8'h00, 4'd0);
        expect_done("clr_empty_mask", 2, 0, 4'h0, 4'h0, 2'b00, 8'h00, 1'b0, 8'h00, 8'h00);

        send(3'b000, 8'hFF, 3'b000, 8'h00, 4'd5);
        expect_done("nop", 1, 0, 4'h0, 4'h0, 2'b00, 8'h00, 1'b0, 8'h00, 8'h00);

        send(3'b111, 8'hFF, 3'b000, 8'h00, 4'd5);
        expect_done("reserved", 1, 0, 4'h0, 4'h0, 2'b00, 8'h00, 1'b0, 8'h00, 8'h00);

        send(3'b011, 8'hFF, 3'b000, 8'h00, 4'd0);
        a_inc = acc_cyc;
        expect_done("inc_count0", 1, 0, 4'h0, 4'h0, 2'b00, 8'h00, 1'b0, 8'h00, 8'h00);

        send(3'b001, 8'hFF, 3'b000, 8'h00, 4'd0);
        chk("clr_back_to_back_accept", acc_cyc, a_inc + 1);
        for (int i = 0; i < 8; i++) exp_rf[i] = 8'h00;
        expect_done("clr_all", 2, 1, 4'hF, 4'hF, 2'b00, 8'hC7, 1'b0, 8'h00, 8'h00);

        send(3'b010, 8'h01, 3'b000, 8'h20, 4'd0);
        exp_rf[3] = 8'h20;
        expect_done("load_t4_20", 2, 1, 4'h0, 4'h1, 2'b01, 8'h20, 1'b0, 8'h00, 8'h00);
        drain();

        // DEC x10 on T4; reset lands on the edge that would launch the 4th strobe.
        send(3'b100, 8'h01, 3'b000, 8'h00, 4'd10);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("dec_rst_ready_low", cmd_ready, 1'b0);
        @(negedge clk);
        chk("dec_rst_strobes", {rf_RSel, rf_TSel}, 0);
        chk("dec_rst_busy", busy, 1'b0);
        chk("dec_rst_rd_data", {rd_data1, rd_data2}, 0);
        rst = 1'b0;
        #1;
        chk("dec_rst_ready_high", cmd_ready, 1'b1);
        n = 0;
        repeat (12) begin
            @(negedge clk);
            if (rf_RSel != 4'd0 || rf_TSel != 4'd0 || done) n++;
        end
        chk("dec_rst_quiet", n, 0);
        exp_rf[3] = 8'h1D;
        chk("dec_rst_t4", rf[3], exp_rf[3]);

        send(3'b100, 8'h01, 3'b000, 8'h00, 4'd2);
        exp_rf[3] = 8'h1B;
        expect_done("dec2_after_reset", 3, 2, 4'h0, 4'h1, 2'b10, 8'h00, 1'b0, 8'h00, 8'h00);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at 200us, expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/rf_sequencer.md
# rf_sequencer

Command-driven initiator for the 8-register file (R1–R4, T1–T4). Accepts one register-file command per valid/ready handshake and expands it into a cycle-accurate sequence on the register file's control port (FunSel, RSel, TSel, O1Sel, O2Sel, I), reading results back through O1/O2. It sits between the control unit and the register file. It owns multi-cycle operations (repeat increment/decrement, register-to-register move, dual readback), so upstream logic issues single commands.

## Interface
- No parameters; all widths are fixed by the register file port.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  sequencer can accept; high only in IDLE.
- `cmd_op`  in  3  000 NOP, 001 CLR, 010 LOAD, 011 INC, 100 DEC, 101 MOVE, 110 READ, 111 reserved (treated as NOP).
- `cmd_dst`  in  8  destination mask: [7:4] drives RSel, [3:0] drives TSel.
- `cmd_src`  in  3  O1Sel code for MOVE/READ.
- `cmd_data`  in  8  immediate for LOAD; [2:0] is the O2Sel code for READ.
- `cmd_count`  in  4  repeat count for INC/DEC.
- `rf_I`, `rf_FunSel`, `rf_RSel`, `rf_TSel`, `rf_O1Sel`, `rf_O2Sel`  out  8/2/4/4/3/3  registered register-file controls.
- `rf_O1`, `rf_O2`  in  8  register-file outputs. The register file updates these on the edge that samples the select code.
- `busy`  out  1  command in progress.
- `done`  out  1  one-cycle pulse when a command completes.
- `rd_data1`, `rd_data2`  out  8  READ results, held until the next READ completes.
- `rd_valid`  out  1  one-cycle pulse, coincident with `done` for READ.

## Operation
- States: IDLE, EXEC, ISSUE, CAPTURE, WRITE.
- Handshake: a command is accepted on an edge with `cmd_valid && cmd_ready`. Command fields are latched internally at acceptance, and inputs are don't-care afterwards.
- Idle drive: `rf_RSel` and `rf_TSel` are 0 in every cycle except strobe cycles, so the register file holds. `rf_FunSel`, `rf_I` and the select codes keep their last value.
- NOP or reserved: IDLE → IDLE, with `done` pulsing in the next cycle. No strobe is issued.
- CLR: EXEC drives one strobe cycle with FunSel=00 and RSel/TSel=dst.
- LOAD: EXEC drives one strobe cycle with FunSel=01 and I=cmd_data.
- INC/DEC: EXEC drives `cmd_count` consecutive strobe cycles with FunSel=11 (INC) or 10 (DEC).
  - An internal 4-bit down-counter tracks the cycles.
  - `cmd_count`=0 issues no strobe; the command completes like a NOP.
  - Register wrap-around (FF+1 → 00) is the register file's behaviour; the sequencer does not saturate.
- MOVE:
  - ISSUE: drive O1Sel=src with no strobe.
  - CAPTURE: latch `rf_O1` at the closing edge.
  - WRITE: drive FunSel=01, I=latched value, RSel/TSel=dst.
  - If the source register is also in the destination mask, the register is rewritten with its own value.
- READ:
  - ISSUE: drive O1Sel=src and O2Sel=cmd_data[2:0].
  - CAPTURE: `rd_data1`←`rf_O1` and `rd_data2`←`rf_O2` at the closing edge.
  - The block then returns to IDLE, with `rd_valid` and `done` pulsing.
- A destination mask of 0 is legal: strobe cycles occur with empty selects and `done` still pulses.
- Busy is high from the cycle after acceptance until the last strobe or CAPTURE cycle.

## Timing
- Reset values:
  - `cmd_ready`=1 in the first cycle after `rst` deasserts; it is 0 while `rst` is high.
  - All `rf_*` outputs = 0.
  - `busy`, `done`, `rd_valid` = 0; `rd_data1`, `rd_data2` = 0.
- Latency from the acceptance edge to the `done` cycle:
  - CLR/LOAD: 2 cycles.
  - INC/DEC: count+1 cycles (1 when count=0).
  - MOVE: 4 cycles.
  - READ: 3 cycles.
  - NOP: 1 cycle.
- `done` coincides with `cmd_ready`=1, so back-to-back commands are accepted on the `done` edge.
- Reset asserted mid-command: at that edge the block returns to IDLE, strobes drop to 0, and `done`/`rd_valid` are not pulsed. `rd_data` is cleared.

## Configuration
- `RF_SEQ_READBACK_EN`
  - Defined: the READ op is implemented as above.
  - Undefined: op 110 is treated as NOP; `rd_data1`, `rd_data2` and `rd_valid` are tied to 0; `rf_O2Sel` is tied to 0 and the `rf_O2` input is unused.
  - CLR, LOAD, INC, DEC and MOVE are unaffected either way.

## Test plan
- Reset, then LOAD with dst=8'h80 and data=8'h5A → exactly one strobe cycle with RSel=1000, FunSel=01, I=5A; `done` pulses 2 cycles after acceptance.
- INC with dst=8'h01 and count=3 on T4=FE → 3 consecutive strobe cycles with TSel=0001, FunSel=11; T4 ends at 01 (wrap-around).
- MOVE src=3'b100 (R1=5A), dst=8'h10 → ISSUE with O1Sel=100, then CAPTURE, then WRITE with RSel=0001, I=5A; R4=5A; `done` at acceptance+4.
- READ src=3'b111, cmd_data[2:0]=3'b000 with R4=33 and T1=C7 → `rd_data1`=33, `rd_data2`=C7, with `rd_valid` and `done` at acceptance+3.
  - Macro undefined: `rd_valid` stays 0 and `done` pulses at acceptance+1.
- DEC with count=10, `rst` pulsed in the 4th strobe cycle → no further strobes, no `done`, `cmd_ready`=1 after reset, register decremented exactly 3 times.
- INC with count=0, followed immediately by CLR dst=8'hFF → no strobe for the INC; `done` at acceptance+1; CLR accepted on that edge; all registers 00 after the CLR strobe.
